// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap and mret sequencer.
// Detects exceptions and enabled interrupts at instruction boundaries, then
// steps the CSR trap channel through mepc/mcause/mtval/mstatus writes and
// redirects the PC to mtvec. An mret restores mstatus and jumps to mepc.
module trap_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] inst_i,
   input  logic        ecall_i,
   input  logic        ebreak_i,
   input  logic        illegal_i,
   input  logic        mret_i,
   input  logic        ex_trap_i,
   input  logic        soft_trap_i,
   input  logic        tcmp_trap_i,
   input  logic        mstatus_mie_i,
   output logic        trap_csr_we_o,
   output logic [11:0] trap_csr_addr_o,
   output logic [31:0] trap_csr_wdata_o,
   input  logic [31:0] trap_csr_rdata_i,
   output logic        hold_o,
   output logic        jump_o,
   output logic [31:0] jump_addr_o
);

   // Machine-mode CSR addresses used on the trap channel.
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_MEPC      = 3'd1;
   localparam logic [2:0] S_MCAUSE    = 3'd2;
   localparam logic [2:0] S_MTVAL     = 3'd3;
   localparam logic [2:0] S_MSTATUS   = 3'd4;
   localparam logic [2:0] S_JUMP      = 3'd5;
   localparam logic [2:0] S_MRET_ST   = 3'd6;
   localparam logic [2:0] S_MRET_JUMP = 3'd7;

   // Trap entry: MPIE <= MIE, MIE <= 0, everything else untouched.
   function automatic logic [31:0] mstatus_on_trap(input logic [31:0] v);
      logic [31:0] r;
      r    = v;
      r[7] = v[3];
      r[3] = 1'b0;
      return r;
   endfunction

   // Return: MIE <= MPIE, MPIE <= 1, everything else untouched.
   function automatic logic [31:0] mstatus_on_mret(input logic [31:0] v);
      logic [31:0] r;
      r    = v;
      r[3] = v[7];
      r[7] = 1'b1;
      return r;
   endfunction

   logic [2:0]  state_q, state_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] tval_q, tval_d;

   logic        trap_take_s;
   logic        mret_take_s;
   logic [31:0] cause_sel_s;
   logic [31:0] tval_sel_s;

   // Boundary take decision with fixed priority: exceptions, enabled IRQs, mret.
   always_comb begin
      trap_take_s = 1'b0;
      mret_take_s = 1'b0;
      cause_sel_s = 32'h0000_0000;
      tval_sel_s  = 32'h0000_0000;
      if (state_q == S_IDLE && inst_valid_i) begin
         if (illegal_i) begin
            trap_take_s = 1'b1;
            cause_sel_s = 32'h0000_0002;
            tval_sel_s  = inst_i;
         end else if (ebreak_i) begin
            trap_take_s = 1'b1;
            cause_sel_s = 32'h0000_0003;
         end else if (ecall_i) begin
            trap_take_s = 1'b1;
            cause_sel_s = 32'h0000_000B;
         end else if (mstatus_mie_i && ex_trap_i) begin
            trap_take_s = 1'b1;
            cause_sel_s = 32'h8000_000B;
         end else if (mstatus_mie_i && soft_trap_i) begin
            trap_take_s = 1'b1;
            cause_sel_s = 32'h8000_0003;
         end else if (mstatus_mie_i && tcmp_trap_i) begin
            trap_take_s = 1'b1;
            cause_sel_s = 32'h8000_0007;
         end else if (mret_i) begin
            mret_take_s = 1'b1;
         end else begin
            trap_take_s = 1'b0;
         end
      end else begin
         trap_take_s = 1'b0;
      end
   end

   // Next-state and capture logic; cause/mtval/mepc freeze at take.
   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      tval_d  = tval_q;
      case (state_q)
         S_IDLE: begin
            if (trap_take_s) begin
               state_d = S_MEPC;
               epc_d   = pc_i;
               cause_d = cause_sel_s;
               tval_d  = tval_sel_s;
            end else if (mret_take_s) begin
               state_d = S_MRET_ST;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MEPC:      state_d = S_MCAUSE;
         S_MCAUSE:    state_d = S_MTVAL;
         S_MTVAL:     state_d = S_MSTATUS;
         S_MSTATUS:   state_d = S_JUMP;
         S_JUMP:      state_d = S_IDLE;
         S_MRET_ST:   state_d = S_MRET_JUMP;
         S_MRET_JUMP: state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // State and captured trap information, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         epc_q   <= 32'h0000_0000;
         cause_q <= 32'h0000_0000;
         tval_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         tval_q  <= tval_d;
      end
   end

   // CSR channel and redirect drive per state; reset suppresses any write or jump at once.
   always_comb begin
      trap_csr_we_o    = 1'b0;
      trap_csr_addr_o  = 12'h000;
      trap_csr_wdata_o = 32'h0000_0000;
      jump_o           = 1'b0;
      jump_addr_o      = 32'h0000_0000;
      case (state_q)
         S_IDLE: begin
            trap_csr_we_o = 1'b0;
         end
         S_MEPC: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = CSR_MEPC;
            trap_csr_wdata_o = epc_q;
         end
         S_MCAUSE: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = CSR_MCAUSE;
            trap_csr_wdata_o = cause_q;
         end
         S_MTVAL: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = CSR_MTVAL;
            trap_csr_wdata_o = tval_q;
         end
         S_MSTATUS: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = CSR_MSTATUS;
            trap_csr_wdata_o = mstatus_on_trap(trap_csr_rdata_i);
         end
         S_JUMP: begin
            trap_csr_addr_o = CSR_MTVEC;
            jump_o          = 1'b1;
            jump_addr_o     = {trap_csr_rdata_i[31:2], 2'b00};
         end
         S_MRET_ST: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = CSR_MSTATUS;
            trap_csr_wdata_o = mstatus_on_mret(trap_csr_rdata_i);
         end
         S_MRET_JUMP: begin
            trap_csr_addr_o = CSR_MEPC;
            jump_o          = 1'b1;
            jump_addr_o     = trap_csr_rdata_i;
         end
         default: begin
            trap_csr_we_o = 1'b0;
         end
      endcase
      if (rst) begin
         trap_csr_we_o = 1'b0;
         jump_o        = 1'b0;
      end else begin
         jump_o = jump_o;
      end
   end

   // Pipeline hold: immediate on a boundary take, then for the whole sequence.
   always_comb begin
      if (state_q == S_IDLE) begin
         hold_o = trap_take_s | mret_take_s;
      end else begin
         hold_o = 1'b1;
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl with a small CSR file model.
module tb_trap_ctrl;

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MTVAL   = 12'h343;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid, ecall, ebreak, illegal, mret;
   logic        ex_trap, soft_trap, tcmp_trap;
   logic [31:0] pc, inst;
   logic        we, hold, jump;
   logic [11:0] addr;
   logic [31:0] wdata, rdata, jump_addr;

   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
   logic        pl_en;
   logic [11:0] pl_addr;
   logic [31:0] pl_data;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      bit          jmp;
      logic [11:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   trap_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .inst_valid_i     (inst_valid),
      .pc_i             (pc),
      .inst_i           (inst),
      .ecall_i          (ecall),
      .ebreak_i         (ebreak),
      .illegal_i        (illegal),
      .mret_i           (mret),
      .ex_trap_i        (ex_trap),
      .soft_trap_i      (soft_trap),
      .tcmp_trap_i      (tcmp_trap),
      .mstatus_mie_i    (m_mstatus[3]),
      .trap_csr_we_o    (we),
      .trap_csr_addr_o  (addr),
      .trap_csr_wdata_o (wdata),
      .trap_csr_rdata_i (rdata),
      .hold_o           (hold),
      .jump_o           (jump),
      .jump_addr_o      (jump_addr)
   );

   always #5 clk = ~clk;

   // Cycle counter used to time-stamp expected channel events.
   always @(posedge clk) cyc <= cyc + 1;

   // CSR file model: bench preloads take precedence over DUT writes.
   always @(posedge clk) begin
      if (pl_en) begin
         case (pl_addr)
            A_MSTATUS: m_mstatus <= pl_data;
            A_MTVEC:   m_mtvec   <= pl_data;
            A_MEPC:    m_mepc    <= pl_data;
            default:   m_mcause  <= pl_data;
         endcase
      end else if (we) begin
         case (addr)
            A_MSTATUS: m_mstatus <= wdata;
            A_MTVEC:   m_mtvec   <= wdata;
            A_MEPC:    m_mepc    <= wdata;
            A_MCAUSE:  m_mcause  <= wdata;
            A_MTVAL:   m_mtval   <= wdata;
            default:   m_mtval   <= m_mtval;
         endcase
      end
   end

   // Combinational CSR read port.
   always_comb begin
      case (addr)
         A_MSTATUS: rdata = m_mstatus;
         A_MTVEC:   rdata = m_mtvec;
         A_MEPC:    rdata = m_mepc;
         A_MCAUSE:  rdata = m_mcause;
         A_MTVAL:   rdata = m_mtval;
         default:   rdata = 32'h0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: every write or jump on the channel must match the next expected event.
   always @(negedge clk) begin
      if (we || jump) begin
         if (sbq.size() == 0) begin
            chk("unexpected_event", {19'h0, jump, addr}, 32'h0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("evt_cycle", cyc, e.cyc);
            chk("evt_kind", {31'h0, jump}, {31'h0, e.jmp});
            if (e.jmp) begin
               chk("jump_addr", jump_addr, e.data);
               chk("jump_we", {31'h0, we}, 32'h0);
            end else begin
               chk("wr_addr", {20'h0, addr}, {20'h0, e.addr});
               chk("wr_data", wdata, e.data);
            end
         end
      end
   end

   task automatic push(input bit j, input logic [11:0] a, input logic [31:0] d, input int c);
      exp_t e;
      e.jmp = j; e.addr = a; e.data = d; e.cyc = c;
      sbq.push_back(e);
   endtask

   task automatic clear_inputs();
      inst_valid = 1'b0; ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0; mret = 1'b0;
      ex_trap = 1'b0; soft_trap = 1'b0; tcmp_trap = 1'b0;
      pc = 32'h0; inst = 32'h0000_0013;
   endtask

   // Load one CSR of the model; ends one cycle later, #1 after the edge.
   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Drive one boundary that must enter a trap; inputs already set by caller.
   // Expected mstatus uses MPIE<=MIE, MIE<=0 on the value held at take time.
   task automatic expect_trap(input logic [31:0] p, input logic [31:0] cause,
                              input logic [31:0] tval, input logic [31:0] mst_before,
                              input logic [31:0] tvec, input string tag);
      int t0;
      logic [31:0] mst_exp;
      t0 = cyc;
      mst_exp = (mst_before & 32'hFFFF_FF77) | {24'h0, mst_before[3], 7'h0};
      push(1'b0, A_MEPC,    p,     t0 + 1);
      push(1'b0, A_MCAUSE,  cause, t0 + 2);
      push(1'b0, A_MTVAL,   tval,  t0 + 3);
      push(1'b0, A_MSTATUS, mst_exp, t0 + 4);
      push(1'b1, 12'h000,   {tvec[31:2], 2'b00}, t0 + 5);
      @(negedge clk);
      chk({tag, "_hold_take"}, {31'h0, hold}, 32'h1);
      @(posedge clk); #1;
      clear_inputs();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk({tag, "_hold_seq"}, {31'h0, hold}, 32'h1);
      end
   endtask

   // Next cycle with no request: DUT idle and all expected events consumed.
   task automatic expect_idle(input string tag);
      @(posedge clk); #1;
      chk({tag, "_sb_empty"}, sbq.size(), 32'h0);
      @(negedge clk);
      chk({tag, "_hold_idle"}, {31'h0, hold}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      clear_inputs();
      pl_en = 1'b0; pl_addr = 12'h0; pl_data = 32'h0;
      m_mstatus = 32'h0; m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_hold", {31'h0, hold}, 32'h0);
      chk("rst_we", {31'h0, we}, 32'h0);
      chk("rst_addr", {20'h0, addr}, 32'h0);
      chk("rst_wdata", wdata, 32'h0);
      chk("rst_jump", {31'h0, jump}, 32'h0);
      chk("rst_jaddr", jump_addr, 32'h0);
      @(posedge clk); #1;

      // External interrupt
      preload(A_MSTATUS, 32'h8);
      preload(A_MTVEC, 32'h100);
      inst_valid = 1'b1; ex_trap = 1'b1; pc = 32'h40;
      expect_trap(32'h40, 32'h8000_000B, 32'h0, 32'h8, 32'h100, "ext");
      expect_idle("ext");
      chk("ext_mstatus", m_mstatus, 32'h80);

      // Illegal beats a pending timer interrupt
      preload(A_MSTATUS, 32'h8);
      inst_valid = 1'b1; illegal = 1'b1; tcmp_trap = 1'b1; inst = 32'hFFFF_FFFF; pc = 32'h80;
      expect_trap(32'h80, 32'h2, 32'hFFFF_FFFF, 32'h8, 32'h100, "ill");
      expect_idle("ill");
      chk("ill_mtval", m_mtval, 32'hFFFF_FFFF);

      // mret
      preload(A_MSTATUS, 32'h80);
      preload(A_MEPC, 32'h44);
      inst_valid = 1'b1; mret = 1'b1; pc = 32'h60;
      t0 = cyc;
      push(1'b0, A_MSTATUS, 32'h88, t0 + 1);
      push(1'b1, 12'h000, 32'h44, t0 + 2);
      @(negedge clk);
      chk("mret_hold_take", {31'h0, hold}, 32'h1);
      @(posedge clk); #1;
      clear_inputs();
      repeat (2) begin
         @(negedge clk);
         chk("mret_hold_seq", {31'h0, hold}, 32'h1);
      end
      expect_idle("mret");

      // Interrupts masked: no take
      preload(A_MSTATUS, 32'h0);
      inst_valid = 1'b1; ex_trap = 1'b1; soft_trap = 1'b1; tcmp_trap = 1'b1; pc = 32'h90;
      repeat (3) begin
         @(negedge clk);
         chk("mask_hold", {31'h0, hold}, 32'h0);
         @(posedge clk); #1;
      end
      clear_inputs();
      expect_idle("mask");

      // mret loses to an enabled software interrupt
      preload(A_MSTATUS, 32'h8);
      inst_valid = 1'b1; mret = 1'b1; soft_trap = 1'b1; pc = 32'h200;
      expect_trap(32'h200, 32'h8000_0003, 32'h0, 32'h8, 32'h100, "mretirq");
      expect_idle("mretirq");
      chk("mretirq_mepc", m_mepc, 32'h200);

      // ebreak beats ecall; mtvec low bits dropped; then back-to-back ecall
      preload(A_MSTATUS, 32'h8);
      preload(A_MTVEC, 32'h103);
      inst_valid = 1'b1; ebreak = 1'b1; ecall = 1'b1; pc = 32'h300;
      expect_trap(32'h300, 32'h3, 32'h0, 32'h8, 32'h103, "ebrk");
      @(posedge clk); #1;
      chk("b2b_sb_empty", sbq.size(), 32'h0);
      inst_valid = 1'b1; ecall = 1'b1; ex_trap = 1'b1; pc = 32'h100;
      expect_trap(32'h100, 32'hB, 32'h0, 32'h80, 32'h103, "b2b");
      expect_idle("b2b");
      chk("b2b_mstatus", m_mstatus, 32'h0);

      // Reset while in MCAUSE
      preload(A_MSTATUS, 32'h8);
      preload(A_MEPC, 32'h0);
      inst_valid = 1'b1; tcmp_trap = 1'b1; pc = 32'h500;
      t0 = cyc;
      push(1'b0, A_MEPC, 32'h500, t0 + 1);
      @(posedge clk); #1;
      clear_inputs();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_hold", {31'h0, hold}, 32'h0);
      chk("rstmid_we", {31'h0, we}, 32'h0);
      chk("rstmid_jump", {31'h0, jump}, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      chk("rstmid_sb_empty", sbq.size(), 32'h0);
      chk("rstmid_mstatus", m_mstatus, 32'h8);
      chk("rstmid_mepc", m_mepc, 32'h500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
